// File: rtl/alarm_supervisor.sv
// Smoke/overcurrent alarm supervisor: synchronised + debounced smoke input,
// threshold compare on current, NORMAL -> ALERTA -> latched ALARMA escalation.
module alarm_supervisor #(
  parameter int N      = 3,
  parameter int UMBRAL = 5,
  parameter int DEB    = 4,
  parameter int ESCALA = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         humo,
  input  logic [N-1:0] corriente,
  input  logic         ack,
  output logic         luz_normal,
  output logic         luz_alerta,
  output logic         alarma,
  output logic [3:0]   hexa3,
  output logic [3:0]   hexa2,
  output logic [3:0]   hexa1,
  output logic [3:0]   hexa0
);

  localparam int DW = $clog2(DEB + 1);
  localparam int TW = (ESCALA > 1) ? $clog2(ESCALA) : 1;

  localparam logic [1:0] S_NORMAL = 2'd0;
  localparam logic [1:0] S_ALERTA = 2'd1;
  localparam logic [1:0] S_ALARMA = 2'd2;

  localparam logic [N-1:0]  UMBRAL_Q   = N'(UMBRAL);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEB);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ESCALA - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_debCnt;
  logic          r_humoDeb;
  logic [N-1:0]  r_corrQ;
  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_evCnt;
  logic          r_luzNormal;
  logic          r_luzAlerta;
  logic          r_alarma;
  logic [3:0]    r_hexa3;

  logic          w_oc;
  logic          w_ev;
  logic [1:0]    w_stateNext;
  logic [TW-1:0] w_timerNext;
  logic [7:0]    w_evCntNext;

  // The counter saturates at DEB so a long smoke event cannot wrap and drop humo_deb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_debCnt  <= '0;
      r_humoDeb <= 1'b0;
      r_corrQ   <= '0;
    end else begin
      r_sync1 <= humo;
      r_sync2 <= r_sync1;
      r_corrQ <= corriente;
      if (r_sync2) begin
        if (r_debCnt != DEB_MAX) begin
          r_debCnt <= r_debCnt + 1'b1;
        end
        r_humoDeb <= (r_debCnt >= DEB_LAST);
      end else begin
        r_debCnt  <= '0;
        r_humoDeb <= 1'b0;
      end
    end
  end

  assign w_oc = (r_corrQ > UMBRAL_Q);
  assign w_ev = r_humoDeb | w_oc;

  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer;
    w_evCntNext = r_evCnt;
    case (r_state)
      S_NORMAL: begin
        if (w_ev) begin
          w_stateNext = S_ALERTA;
          w_timerNext = '0;
        end
      end
      S_ALERTA: begin
        if (!w_ev) begin
          w_stateNext = S_NORMAL;
        end else if (r_timer == TIMER_LAST) begin
          w_stateNext = S_ALARMA;
          if (r_evCnt != 8'hFF) begin
            w_evCntNext = r_evCnt + 8'd1;
          end
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
      end
      S_ALARMA: begin
        if (ack && !w_ev) begin
          w_stateNext = S_NORMAL;
        end
      end
      default: w_stateNext = S_NORMAL;
    endcase
  end

  // Lights decode from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_NORMAL;
      r_timer     <= '0;
      r_evCnt     <= 8'd0;
      r_luzNormal <= 1'b1;
      r_luzAlerta <= 1'b0;
      r_alarma    <= 1'b0;
      r_hexa3     <= 4'd0;
    end else begin
      r_state     <= w_stateNext;
      r_timer     <= w_timerNext;
      r_evCnt     <= w_evCntNext;
      r_luzNormal <= (w_stateNext == S_NORMAL);
      r_luzAlerta <= (w_stateNext != S_NORMAL);
      r_alarma    <= (w_stateNext == S_ALARMA);
      r_hexa3     <= {2'b00, w_stateNext};
    end
  end

  assign luz_normal = r_luzNormal;
  assign luz_alerta = r_luzAlerta;
  assign alarma     = r_alarma;
  assign hexa3      = r_hexa3;
  assign hexa2      = 4'(r_corrQ);
  assign hexa1      = r_evCnt[7:4];
  assign hexa0      = r_evCnt[3:0];

endmodule

// File: tb/tb_alarm_supervisor.sv
// Self-checking bench for alarm_supervisor: vector table plus hand sequences
// for reset and counter saturation, checked through an expectation queue.
module tb_alarm_supervisor;

   localparam logic [1:0] ST_N = 2'd0;
   localparam logic [1:0] ST_A = 2'd1;
   localparam logic [1:0] ST_M = 2'd2;

   typedef struct {
      logic       humo;
      logic [2:0] corr;
      logic       ack;
      logic [1:0] st;
      logic [7:0] cnt;
      int         reps;
   } vec_t;

   typedef struct {
      logic [1:0] st;
      logic [3:0] h2;
      logic [7:0] cnt;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       humo;
   logic [2:0] corriente;
   logic       ack;
   logic       luzNormal;
   logic       luzAlerta;
   logic       alarma;
   logic [3:0] hexa3;
   logic [3:0] hexa2;
   logic [3:0] hexa1;
   logic [3:0] hexa0;

   int   checks = 0;
   int   errors = 0;
   int   step   = 0;
   exp_t sbQ[$];
   vec_t vecs[24];

   alarm_supervisor #(.N(3), .UMBRAL(5), .DEB(4), .ESCALA(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .humo       (humo),
      .corriente  (corriente),
      .ack        (ack),
      .luz_normal (luzNormal),
      .luz_alerta (luzAlerta),
      .alarma     (alarma),
      .hexa3      (hexa3),
      .hexa2      (hexa2),
      .hexa1      (hexa1),
      .hexa0      (hexa0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One field comparison; every call is one counted check.
   task automatic checkField(input string nm, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s step %0d got %0h want %0h", nm, step, got, want);
      end
   endtask

   // Pops the oldest expectation and compares every output against it.
   task automatic checkOutput();
      exp_t e;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard step %0d got empty want entry", step);
         return;
      end
      e = sbQ.pop_front();
      checkField("luz_normal", {7'd0, luzNormal}, {7'd0, (e.st == ST_N)});
      checkField("luz_alerta", {7'd0, luzAlerta}, {7'd0, (e.st != ST_N)});
      checkField("alarma",     {7'd0, alarma},    {7'd0, (e.st == ST_M)});
      checkField("hexa3",      {4'd0, hexa3},     {6'd0, e.st});
      checkField("hexa2",      {4'd0, hexa2},     {4'd0, e.h2});
      checkField("hexa1",      {4'd0, hexa1},     {4'd0, e.cnt[7:4]});
      checkField("hexa0",      {4'd0, hexa0},     {4'd0, e.cnt[3:0]});
      step++;
   endtask

   // Drives one cycle of inputs, queues the outputs expected after the next edge, then checks them.
   task automatic applyStimulus(input logic h, input logic [2:0] c, input logic a,
                                input logic [1:0] st, input logic [7:0] cnt);
      exp_t e;
      @(negedge clk);
      humo      = h;
      corriente = c;
      ack       = a;
      e.st  = st;
      e.h2  = {1'b0, c};
      e.cnt = cnt;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      exp_t e;
      logic [7:0] cnt;

      vecs[0]  = '{1'b0, 3'd0, 1'b0, ST_N, 8'd0, 3};
      vecs[1]  = '{1'b0, 3'd5, 1'b0, ST_N, 8'd0, 20};
      vecs[2]  = '{1'b0, 3'd6, 1'b0, ST_N, 8'd0, 1};
      vecs[3]  = '{1'b0, 3'd6, 1'b0, ST_A, 8'd0, 8};
      vecs[4]  = '{1'b0, 3'd6, 1'b0, ST_M, 8'd1, 1};
      vecs[5]  = '{1'b0, 3'd6, 1'b1, ST_M, 8'd1, 1};
      vecs[6]  = '{1'b0, 3'd0, 1'b0, ST_M, 8'd1, 2};
      vecs[7]  = '{1'b0, 3'd0, 1'b1, ST_N, 8'd1, 1};
      vecs[8]  = '{1'b0, 3'd0, 1'b0, ST_N, 8'd1, 1};
      vecs[9]  = '{1'b1, 3'd0, 1'b0, ST_N, 8'd1, 3};
      vecs[10] = '{1'b0, 3'd0, 1'b0, ST_N, 8'd1, 4};
      vecs[11] = '{1'b1, 3'd0, 1'b0, ST_N, 8'd1, 6};
      vecs[12] = '{1'b1, 3'd0, 1'b0, ST_A, 8'd1, 8};
      vecs[13] = '{1'b1, 3'd0, 1'b0, ST_M, 8'd2, 1};
      vecs[14] = '{1'b0, 3'd0, 1'b1, ST_M, 8'd2, 3};
      vecs[15] = '{1'b0, 3'd0, 1'b1, ST_N, 8'd2, 1};
      vecs[16] = '{1'b0, 3'd0, 1'b0, ST_N, 8'd2, 2};
      vecs[17] = '{1'b0, 3'd7, 1'b0, ST_N, 8'd2, 1};
      vecs[18] = '{1'b0, 3'd7, 1'b0, ST_A, 8'd2, 3};
      vecs[19] = '{1'b0, 3'd0, 1'b0, ST_A, 8'd2, 1};
      vecs[20] = '{1'b0, 3'd0, 1'b0, ST_N, 8'd2, 3};
      vecs[21] = '{1'b0, 3'd7, 1'b0, ST_N, 8'd2, 1};
      vecs[22] = '{1'b0, 3'd7, 1'b0, ST_A, 8'd2, 8};
      vecs[23] = '{1'b0, 3'd7, 1'b0, ST_M, 8'd3, 1};

      reset     = 1'b1;
      humo      = 1'b0;
      corriente = 3'd0;
      ack       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e = '{ST_N, 4'd0, 8'd0};
      sbQ.push_back(e);
      checkOutput();
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] vector table");
      for (int i = 0; i < 24; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            applyStimulus(vecs[i].humo, vecs[i].corr, vecs[i].ack, vecs[i].st, vecs[i].cnt);
         end
      end

      $display("[TB] reset during alarm");
      reset     = 1'b1;
      corriente = 3'd0;
      #1;
      e = '{ST_N, 4'd0, 8'd0};
      sbQ.push_back(e);
      checkOutput();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int r = 0; r < 4; r++) begin
         applyStimulus(1'b0, 3'd0, 1'b0, ST_N, 8'd0);
      end

      $display("[TB] counter saturation");
      cnt = 8'd0;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b0, 3'd7, 1'b0, ST_N, cnt);
         for (int r = 0; r < 8; r++) begin
            applyStimulus(1'b0, 3'd7, 1'b0, ST_A, cnt);
         end
         if (cnt != 8'hFF) cnt = cnt + 8'd1;
         applyStimulus(1'b0, 3'd7, 1'b0, ST_M, cnt);
         applyStimulus(1'b0, 3'd0, 1'b0, ST_M, cnt);
         applyStimulus(1'b0, 3'd0, 1'b1, ST_N, cnt);
      end
      applyStimulus(1'b0, 3'd0, 1'b0, ST_N, 8'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
